// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared keypad FSM states, matrix geometry and row decode
package lock_pkg;

   localparam int KEY_W = 4;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam logic [COLS-1:0] COL_IDLE = 4'b1110;

   typedef enum logic [2:0] {
      SCAN,
      DEBOUNCE,
      PRESSED,
      WAIT_REL,
      REL_DEB
   } kp_state_e;

   typedef struct packed {
      logic       hit;
      logic [1:0] row;
   } row_hit_t;

   // Exactly one low row is a key; none or several (ghosting) is no key.
   function automatic row_hit_t decode_rows(input logic [ROWS-1:0] rows_n);
      row_hit_t res;
      int       n;
      res = '0;
      n   = 0;
      for (int r = 0; r < ROWS; r++) begin
         if (!rows_n[r]) begin
            n++;
            res.row = 2'(r);
         end
      end
      res.hit = (n == 1);
      return res;
   endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// rtl/keypad_debounce_fsm.sv - row synchronizer, column scan and press/release debounce FSM
module keypad_debounce_fsm
   import lock_pkg::*;
#(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 16
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [ROWS-1:0]  row_in,
   output logic [COLS-1:0]  col_out,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             busy
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic [ROWS-1:0]  row_s1_q, row_s2_q;
   kp_state_e        state_q, state_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [COLS-1:0]  col_out_q, col_out_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic [1:0]       row_lat_q, row_lat_d;
   logic [KEY_W-1:0] key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             busy_q, busy_d;
   row_hit_t         rh;

   always_comb begin
      rh          = decode_rows(row_s2_q);
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      div_d       = div_q;
      deb_d       = deb_q;
      row_lat_d   = row_lat_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      case (state_q)
         SCAN: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (rh.hit) begin
                  row_lat_d = rh.row;
                  deb_d     = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rh.hit && rh.row == row_lat_q) begin
               if (deb_q == DEB_LAST) begin
                  state_d     = PRESSED;
                  key_valid_d = 1'b1;
                  key_code_d  = {row_lat_q, col_idx_q};
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               state_d = SCAN;
               div_d   = '0;
            end
         end
         PRESSED: state_d = WAIT_REL;
         WAIT_REL: begin
            if (!rh.hit) begin
               state_d = REL_DEB;
               deb_d   = '0;
            end
         end
         REL_DEB: begin
            if (rh.hit) begin
               state_d = WAIT_REL;
            end else if (deb_q == DEB_LAST) begin
               state_d = SCAN;
               div_d   = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase
      // The column stays frozen outside SCAN so the debounce watches the latched key.
      col_out_d = ~(COLS'(1) << col_idx_d);
      busy_d    = (state_d != SCAN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_s1_q    <= '1;
         row_s2_q    <= '1;
         state_q     <= SCAN;
         col_idx_q   <= '0;
         col_out_q   <= COL_IDLE;
         div_q       <= '0;
         deb_q       <= '0;
         row_lat_q   <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         row_s1_q    <= row_in;
         row_s2_q    <= row_s1_q;
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         col_out_q   <= col_out_d;
         div_q       <= div_d;
         deb_q       <= deb_d;
         row_lat_q   <= row_lat_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign col_out   = col_out_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign busy      = busy_q;

endmodule

// File: rtl/keypad_entry_scanner.sv
// rtl/keypad_entry_scanner.sv - keypad scanner plus code-word assembler
// Optional inter-digit timeout with timeout_o is built when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry_scanner
   import lock_pkg::*;
#(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DIGITS          = 4,
`ifdef KEYPAD_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES  = 1024,
`endif
   localparam int CNT_W = $clog2(DIGITS + 1)
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ROWS-1:0]         row_in,
   output logic [COLS-1:0]         col_out,
   input  logic                    clear_in,
   output logic [KEY_W-1:0]        key_code,
   output logic                    key_valid,
   output logic [KEY_W*DIGITS-1:0] code_out,
   output logic                    code_valid,
   output logic [CNT_W-1:0]        digit_cnt,
`ifdef KEYPAD_TIMEOUT_EN
   output logic                    timeout_o,
`endif
   output logic                    busy
);

   localparam int CODE_W = KEY_W * DIGITS;

   logic [CODE_W-1:0] buf_q, buf_d, buf_shift, code_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              clear_all, last_digit;

   keypad_debounce_fsm #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_scan (
      .clk       (clk),
      .reset_n   (reset_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .busy      (busy)
   );

`ifdef KEYPAD_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] to_q, to_d;
   logic            to_run, to_hit, timeout_q;

   assign to_run = (cnt_q != '0) && (cnt_q < CNT_W'(DIGITS)) && !busy;
   assign to_hit = to_run && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      to_d = to_q;
      if (key_valid || to_hit) begin
         to_d = '0;
      end else if (to_run) begin
         to_d = to_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_q      <= to_d;
         timeout_q <= to_hit;
      end
   end

   assign timeout_o = timeout_q;
   assign clear_all = clear_in | to_hit;
`else
   assign clear_all = clear_in;
`endif

   assign buf_shift  = (buf_q << KEY_W) | CODE_W'(key_code);
   assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));
   // Completion is combinational so code_valid lands in the key_valid cycle; a clear drops it.
   assign code_valid = key_valid & ~clear_all & last_digit;
   assign code_out   = code_valid ? buf_shift : code_q;

   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (clear_all) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (key_valid) begin
         if (last_digit) begin
            buf_d = '0;
            cnt_d = '0;
         end else begin
            buf_d = buf_shift;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q  <= '0;
         cnt_q  <= '0;
         code_q <= '0;
      end else begin
         buf_q  <= buf_d;
         cnt_q  <= cnt_d;
         code_q <= code_out;
      end
   end

   assign digit_cnt = cnt_q;

endmodule
